ntt_bf_ctrl: RTL and testbench
==============================

# ntt_bf_ctrl

Butterfly scheduler that drives the NTT butterfly unit from the memory side. It walks all stages of an N-point forward (Cooley-Tukey) or inverse (Gentleman-Sande) transform. Each cycle it issues one coefficient-pair read and one twiddle read, tells the butterfly which mode to use, and writes the results back after a fixed pipeline delay. It sits between the coefficient RAM / twiddle ROM and the butterfly datapath, and it inserts drain bubbles so that no stage reads data the previous stage has not yet written.

## Interface
- LOGN, default 8: log2 of transform size; N = 2^LOGN; legal range 2..12.
- PIPE_LAT, default 2: cycles from rd_en_o to the matching wr_en_o (1 RAM read plus 1 butterfly register); legal range 1..8.
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin a transform; sampled only in IDLE.
- ct_i  in  1  mode at start: 1 = forward CT, 0 = inverse GS.
- busy_o  out  1  transform in progress.
- done_o  out  1  one-cycle completion pulse.
- ct_o  out  1  latched mode, to the butterfly's ct_i.
- rd_en_o  out  1  read strobe for the coefficient RAM and the twiddle ROM.
- rd_a_addr_o, rd_b_addr_o  out  LOGN  read addresses for the coefficient pair.
- tw_addr_o  out  LOGN  twiddle ROM address.
- wr_en_o  out  1  write-back strobe for x/y.
- wr_a_addr_o, wr_b_addr_o  out  LOGN  write addresses; x goes to a, y goes to b.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i. Latch ct_i into ct_o. Clear stage counter s and butterfly counter bf.
  - RUN: issue one butterfly per cycle, bf = 0..N/2-1. On bf = N/2-1, go to DRAIN and clear bf.
  - DRAIN: PIPE_LAT cycles with rd_en_o = 0. When the drain ends, go to RUN with s+1 if s < LOGN-1; otherwise go to DONE.
  - DONE: done_o = 1 for exactly one cycle, then go to IDLE.
- Address generation per stage s:
  - p = LOGN-1-s (CT) or p = s (GS); len = 2^p.
  - group g = bf >> p.
  - a = (g << (p+1)) | (bf & (len-1)); b = a + len. Both are LOGN bits wide and never overflow.
  - Twiddle: CT tw = 2^s + g; GS tw = (N >> (s+1)) + g. Range 1..N-1; address 0 is never used.
- Write-back: a PIPE_LAT-deep shift register carries {valid, a, b}. wr_* is the tail of that shift register, so write order equals read order.
- ct_o is constant for the whole transform.
- start_i while busy_o = 1 is ignored; it does not queue.
- A change on ct_i after start has no effect.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all delay-line valid bits are 0. No write is issued after reset is released.
- Reset asserted mid-transform aborts immediately: outputs are 0 and no further reads, writes, or done_o occur.
- Cycle numbering: start_i is sampled at edge 0.
  - RUN of stage 0 spans cycles 1..N/2.
  - The write for each butterfly occurs PIPE_LAT cycles after its read.
- Per stage: N/2 issue cycles plus PIPE_LAT drain cycles.
  - The last write of stage s lands in the final drain cycle.
  - The first read of stage s+1 comes one cycle later, which is safe for a synchronous write-first RAM.
- Timing totals, with T = LOGN*(N/2+PIPE_LAT):
  - busy_o is high for cycles 1..T.
  - done_o is high at cycle T+1.
  - start_i is accepted again from cycle T+2.
- rd_en_o and wr_en_o are each high for exactly LOGN*N/2 cycles per transform.
- There is no back-pressure; the RAM is assumed ready every cycle.

## Test plan
All cases use LOGN = 3 and PIPE_LAT = 2 unless noted.
- Reset and idle: hold rstn_i low, then release with start_i = 0 -> all outputs stay 0 for 20 cycles.
- CT sequence: start_i with ct_i = 1 -> reads follow this order:
  - Stage 0: (0,4,tw1), (1,5,1), (2,6,1), (3,7,1).
  - Stage 1: (0,2,2), (1,3,2), (4,6,3), (5,7,3).
  - Stage 2: (0,1,4), (2,3,5), (4,5,6), (6,7,7).
  - Stage 2 bubbles: rd_en_o is low at cycles 5-6 and 11-12. done_o is high at cycle 19 only. ct_o = 1 throughout.
- GS sequence: start_i with ct_i = 0 -> reads follow this order:
  - Stage 0: (0,1,4), (2,3,5), (4,5,6), (6,7,7).
  - Stage 1: (0,2,2), (1,3,2), (4,6,3), (5,7,3).
  - Stage 2: (0,4,1), (1,5,1), (2,6,1), (3,7,1).
  - ct_o = 0 throughout.
- Write alignment: wr_a/b_addr_o equals rd_a/b_addr_o delayed by exactly 2 cycles, for every read. Repeat with PIPE_LAT = 4: total run is 24 cycles and done_o is high at cycle 25.
- Ignored start and mid-run reset:
  - Pulse start_i with ct_i toggled at cycle 7 -> no change to the sequence or to ct_o.
  - Assert rstn_i at cycle 9 -> outputs are 0 immediately, and after release no wr_en_o and no done_o occur.
- Back-to-back transforms: start_i at cycle 20 (LOGN = 3) -> a new transform begins at cycle 21. A second test with LOGN = 8: done_o is high at cycle 8*(128+2)+1 = 1041.

Source files
------------

// File: rtl/ntt_bf_ctrl_if.sv
// Memory-side bus of the NTT butterfly scheduler.
// master = scheduler, slave = RAM/ROM/butterfly side.
interface ntt_bf_ctrl_if #(
  parameter int LOGN = 8
);
  logic            start_i;
  logic            ct_i;
  logic            busy_o;
  logic            done_o;
  logic            ct_o;
  logic            rd_en_o;
  logic [LOGN-1:0] rd_a_addr_o;
  logic [LOGN-1:0] rd_b_addr_o;
  logic [LOGN-1:0] tw_addr_o;
  logic            wr_en_o;
  logic [LOGN-1:0] wr_a_addr_o;
  logic [LOGN-1:0] wr_b_addr_o;

  modport master (
    input  start_i, ct_i,
    output busy_o, done_o, ct_o,
    output rd_en_o, rd_a_addr_o, rd_b_addr_o, tw_addr_o,
    output wr_en_o, wr_a_addr_o, wr_b_addr_o
  );

  modport slave (
    output start_i, ct_i,
    input  busy_o, done_o, ct_o,
    input  rd_en_o, rd_a_addr_o, rd_b_addr_o, tw_addr_o,
    input  wr_en_o, wr_a_addr_o, wr_b_addr_o
  );
endinterface

// File: rtl/ntt_bf_ctrl.sv
// NTT butterfly scheduler: walks CT/GS stages, issues
// pair/twiddle reads and delayed write-backs with drain bubbles.
module ntt_bf_ctrl #(
  parameter int LOGN     = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  ntt_bf_ctrl_if.master bus
);
  localparam int W = LOGN;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0]   S_LAST  = 4'(LOGN-1);
  localparam logic [3:0]   D_LAST  = 4'(PIPE_LAT-1);
  localparam logic [W-2:0] BF_LAST = '1;

  logic [1:0]   state;
  logic [3:0]   s;
  logic [3:0]   dc;
  logic [W-2:0] bf;
  logic         ct;

  logic         rd;
  logic [3:0]   p;
  logic [W-1:0] bfw;
  logic [W-1:0] mask;
  logic [W-1:0] g;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] tw;

  logic [PIPE_LAT-1:0] dv;
  logic [W-1:0]        da [PIPE_LAT];
  logic [W-1:0]        db [PIPE_LAT];

  // a is bf with a zero bit inserted at position p; b sets that bit
  always_comb begin
    rd   = (state == RUN);
    p    = ct ? (S_LAST - s) : s;
    bfw  = {1'b0, bf};
    mask = (W'(1) << p) - W'(1);
    g    = bfw >> p;
    a    = ((bfw & ~mask) << 1) | (bfw & mask);
    b    = a | (W'(1) << p);
    tw   = ct ? ((W'(1) << s) + g)
              : ((W'(1) << (S_LAST - s)) + g);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      s     <= '0;
      bf    <= '0;
      dc    <= '0;
      ct    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            state <= RUN;
            ct    <= bus.ct_i;
            s     <= '0;
            bf    <= '0;
          end
        end
        RUN: begin
          bf <= bf + 1'b1;
          dc <= '0;
          if (bf == BF_LAST) begin
            bf    <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dc <= dc + 1'b1;
          if (dc == D_LAST) begin
            if (s == S_LAST) begin
              state <= DONE;
            end else begin
              s     <= s + 1'b1;
              state <= RUN;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dv <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        da[i] <= '0;
        db[i] <= '0;
      end
    end else begin
      dv[0] <= rd;
      da[0] <= rd ? a : '0;
      db[0] <= rd ? b : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dv[i] <= dv[i-1];
        da[i] <= da[i-1];
        db[i] <= db[i-1];
      end
    end
  end

  assign bus.busy_o      = (state == RUN) || (state == DRAIN);
  assign bus.done_o      = (state == DONE);
  assign bus.ct_o        = ct;
  assign bus.rd_en_o     = rd;
  assign bus.rd_a_addr_o = rd ? a  : '0;
  assign bus.rd_b_addr_o = rd ? b  : '0;
  assign bus.tw_addr_o   = rd ? tw : '0;
  assign bus.wr_en_o     = dv[PIPE_LAT-1];
  assign bus.wr_a_addr_o = da[PIPE_LAT-1];
  assign bus.wr_b_addr_o = db[PIPE_LAT-1];
endmodule

// File: tb/tb_ntt_bf_ctrl.sv
// Scoreboard bench for ntt_bf_ctrl: LOGN=3 (lat 2 and 4)
// plus a LOGN=8 run against an independent stage-loop model.
module tb_ntt_bf_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic rstn_b;

  ntt_bf_ctrl_if #(.LOGN(3)) if0 ();
  ntt_bf_ctrl_if #(.LOGN(3)) if1 ();
  ntt_bf_ctrl_if #(.LOGN(8)) if2 ();

  ntt_bf_ctrl #(.LOGN(3), .PIPE_LAT(2)) d0 (
    .clk_i(clk), .rstn_i(rstn), .bus(if0)
  );
  ntt_bf_ctrl #(.LOGN(3), .PIPE_LAT(4)) d1 (
    .clk_i(clk), .rstn_i(rstn_b), .bus(if1)
  );
  ntt_bf_ctrl #(.LOGN(8), .PIPE_LAT(2)) d2 (
    .clk_i(clk), .rstn_i(rstn_b), .bus(if2)
  );

  logic [19:0] out0;
  logic [19:0] out1;
  logic [44:0] out2;
  assign out0 = {if0.busy_o, if0.done_o, if0.ct_o, if0.rd_en_o,
                 if0.rd_a_addr_o, if0.rd_b_addr_o, if0.tw_addr_o,
                 if0.wr_en_o, if0.wr_a_addr_o, if0.wr_b_addr_o};
  assign out1 = {if1.busy_o, if1.done_o, if1.ct_o, if1.rd_en_o,
                 if1.rd_a_addr_o, if1.rd_b_addr_o, if1.tw_addr_o,
                 if1.wr_en_o, if1.wr_a_addr_o, if1.wr_b_addr_o};
  assign out2 = {if2.busy_o, if2.done_o, if2.ct_o, if2.rd_en_o,
                 if2.rd_a_addr_o, if2.rd_b_addr_o, if2.tw_addr_o,
                 if2.wr_en_o, if2.wr_a_addr_o, if2.wr_b_addr_o};

  int errs = 0;
  int checks = 0;
  int ec = 0;
  always @(posedge clk) ec <= ec + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // {0,a,0,b,0,tw} one hex digit per field
  logic [11:0] ct_tab [12] = '{
    12'h041, 12'h151, 12'h261, 12'h371,
    12'h022, 12'h132, 12'h463, 12'h573,
    12'h014, 12'h235, 12'h456, 12'h677};
  logic [11:0] gs_tab [12] = '{
    12'h014, 12'h235, 12'h456, 12'h677,
    12'h022, 12'h132, 12'h463, 12'h573,
    12'h041, 12'h151, 12'h261, 12'h371};

  // ---------------- d0 monitor
  int          e0 = 0;
  bit          mon0 = 0;
  logic [11:0] rq0 [$];
  int          wq0 [$];
  int rd_cnt0, wr_cnt0, busy_cnt0, done_cnt0, done_cyc0, ct_bad0;
  logic        ct_exp0;
  bit          rdmap0 [64];

  initial begin
    int c, w;
    logic [11:0] got;
    forever begin
      @(negedge clk);
      if (mon0) begin
        c = ec - e0 + 1;
        if (c >= 0 && c < 64) rdmap0[c] = if0.rd_en_o;
        if (if0.busy_o) busy_cnt0++;
        if (if0.busy_o && if0.ct_o !== ct_exp0) ct_bad0++;
        if (if0.done_o) begin
          done_cnt0++;
          done_cyc0 = c;
        end
        if (if0.rd_en_o) begin
          rd_cnt0++;
          got = {1'b0, if0.rd_a_addr_o, 1'b0, if0.rd_b_addr_o,
                 1'b0, if0.tw_addr_o};
          if (rq0.size() > 0) chk("rd0_tuple", got, rq0.pop_front());
          wq0.push_back(c*256 + int'(if0.rd_a_addr_o)*16
                        + int'(if0.rd_b_addr_o));
        end
        if (if0.wr_en_o) begin
          wr_cnt0++;
          if (wq0.size() > 0) begin
            w = wq0.pop_front();
            chk("wr0_addr", {if0.wr_a_addr_o, 1'b0, if0.wr_b_addr_o},
                {w[6:4], 1'b0, w[2:0]});
            chk("wr0_lat", c - (w >> 8), 2);
          end
        end
      end
    end
  end

  // ---------------- d1 monitor (PIPE_LAT=4)
  int e1 = 0;
  bit mon1 = 0;
  int wq1 [$];
  int rd_cnt1, wr_cnt1, busy_cnt1, done_cnt1, done_cyc1;

  initial begin
    int c, w;
    forever begin
      @(negedge clk);
      if (mon1) begin
        c = ec - e1 + 1;
        if (if1.busy_o) busy_cnt1++;
        if (if1.done_o) begin
          done_cnt1++;
          done_cyc1 = c;
        end
        if (if1.rd_en_o) begin
          rd_cnt1++;
          wq1.push_back(c*256 + int'(if1.rd_a_addr_o)*16
                        + int'(if1.rd_b_addr_o));
        end
        if (if1.wr_en_o) begin
          wr_cnt1++;
          if (wq1.size() > 0) begin
            w = wq1.pop_front();
            chk("wr1_addr", {if1.wr_a_addr_o, 1'b0, if1.wr_b_addr_o},
                {w[6:4], 1'b0, w[2:0]});
            chk("wr1_lat", c - (w >> 8), 4);
          end
        end
      end
    end
  end

  // ---------------- d2 monitor (LOGN=8)
  logic [23:0] rq2 [$];
  int rd_cnt2, wr_cnt2, busy_cnt2, done_cnt2, done_cyc2;

  initial begin
    int c;
    forever begin
      @(negedge clk);
      if (mon1) begin
        c = ec - e1 + 1;
        if (if2.busy_o) busy_cnt2++;
        if (if2.done_o) begin
          done_cnt2++;
          done_cyc2 = c;
        end
        if (if2.wr_en_o) wr_cnt2++;
        if (if2.rd_en_o) begin
          rd_cnt2++;
          if (rq2.size() > 0)
            chk("rd2_tuple", {if2.rd_a_addr_o, if2.rd_b_addr_o,
                              if2.tw_addr_o}, rq2.pop_front());
        end
      end
    end
  end

  task automatic clr0();
    rd_cnt0 = 0; wr_cnt0 = 0; busy_cnt0 = 0;
    done_cnt0 = 0; done_cyc0 = -1; ct_bad0 = 0;
    for (int i = 0; i < 64; i++) rdmap0[i] = 1'b0;
  endtask

  task automatic check_run0(input string tag);
    chk({tag, "_done_cyc"}, done_cyc0, 19);
    chk({tag, "_done_cnt"}, done_cnt0, 1);
    chk({tag, "_busy_cnt"}, busy_cnt0, 18);
    chk({tag, "_rd_cnt"}, rd_cnt0, 12);
    chk({tag, "_wr_cnt"}, wr_cnt0, 12);
    chk({tag, "_rq_left"}, rq0.size(), 0);
    chk({tag, "_ct_bad"}, ct_bad0, 0);
    chk({tag, "_rd4"}, rdmap0[4], 1);
    chk({tag, "_rd5"}, rdmap0[5], 0);
    chk({tag, "_rd6"}, rdmap0[6], 0);
    chk({tag, "_rd7"}, rdmap0[7], 1);
    chk({tag, "_rd11"}, rdmap0[11], 0);
    chk({tag, "_rd12"}, rdmap0[12], 0);
    chk({tag, "_rd13"}, rdmap0[13], 1);
  endtask

  initial begin
    int c;
    logic [19:0] acc;
    logic [2:0] acc3;
    rstn = 1'b0;
    rstn_b = 1'b0;
    if0.start_i = 0; if0.ct_i = 0;
    if1.start_i = 0; if1.ct_i = 0;
    if2.start_i = 0; if2.ct_i = 0;
    clr0();
    repeat (3) @(negedge clk);
    chk("rst_out0", out0, 0);
    chk("rst_out1", out1, 0);
    chk("rst_out2", {31'd0, |out2}, 0);
    rstn = 1'b1;
    rstn_b = 1'b1;

    acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc |= out0;
    end
    chk("idle0", acc, 0);

    // forward CT, with an ignored start pulse at cycle 7
    #2;
    foreach (ct_tab[i]) rq0.push_back(ct_tab[i]);
    ct_exp0 = 1'b1;
    if0.start_i = 1; if0.ct_i = 1;
    @(posedge clk); #1 e0 = ec; mon0 = 1;
    c = 0;
    while (c < 20) begin
      @(negedge clk); #2;
      c = ec - e0 + 1;
      if (c == 1) if0.start_i = 0;
      if (c == 7) begin if0.start_i = 1; if0.ct_i = 0; end
      if (c == 8) if0.start_i = 0;
    end
    check_run0("ct");
    chk("idle_c20", if0.busy_o, 0);

    // inverse GS back-to-back: start during cycle 20
    clr0();
    foreach (gs_tab[i]) rq0.push_back(gs_tab[i]);
    ct_exp0 = 1'b0;
    if0.start_i = 1; if0.ct_i = 0;
    @(posedge clk); #1 e0 = ec;
    c = 0;
    while (c < 20) begin
      @(negedge clk); #2;
      c = ec - e0 + 1;
      if (c == 1) begin
        chk("b2b_busy21", if0.busy_o, 1);
        chk("b2b_rd21", if0.rd_en_o, 1);
        if0.start_i = 0;
        if0.ct_i = 1;
      end
    end
    check_run0("gs");

    // mid-run reset at cycle 9
    clr0();
    foreach (ct_tab[i]) rq0.push_back(ct_tab[i]);
    ct_exp0 = 1'b1;
    if0.start_i = 1; if0.ct_i = 1;
    @(posedge clk); #1 e0 = ec;
    c = 0;
    while (c < 9) begin
      @(negedge clk); #2;
      c = ec - e0 + 1;
      if (c == 1) if0.start_i = 0;
    end
    mon0 = 0;
    chk("pre_rst_busy", if0.busy_o, 1);
    rstn = 1'b0;
    #1 chk("mid_rst_out0", out0, 0);
    rq0.delete();
    wq0.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    acc3 = '0;
    repeat (30) begin
      @(negedge clk);
      acc3 |= {if0.wr_en_o, if0.done_o, if0.rd_en_o};
    end
    chk("post_rst_quiet", acc3, 0);

    // PIPE_LAT=4 GS and LOGN=8 CT, run together
    for (int s = 0; s < 8; s++) begin
      int len;
      len = 1 << (7 - s);
      for (int st = 0; st < 256; st += 2*len)
        for (int j = 0; j < len; j++)
          rq2.push_back({8'(st + j), 8'(st + j + len),
                         8'((1 << s) + st / (2*len))});
    end
    #2;
    if1.start_i = 1; if1.ct_i = 0;
    if2.start_i = 1; if2.ct_i = 1;
    done_cyc1 = -1; done_cyc2 = -1;
    @(posedge clk); #1 e1 = ec; mon1 = 1;
    @(negedge clk); #2;
    if1.start_i = 0;
    if2.start_i = 0;
    repeat (1060) @(negedge clk);
    #2 mon1 = 0;
    chk("l4_done_cyc", done_cyc1, 25);
    chk("l4_done_cnt", done_cnt1, 1);
    chk("l4_busy_cnt", busy_cnt1, 24);
    chk("l4_rd_cnt", rd_cnt1, 12);
    chk("l4_wr_cnt", wr_cnt1, 12);
    chk("l4_ct_o", if1.ct_o, 0);
    chk("n256_done_cyc", done_cyc2, 1041);
    chk("n256_done_cnt", done_cnt2, 1);
    chk("n256_busy_cnt", busy_cnt2, 1040);
    chk("n256_rd_cnt", rd_cnt2, 1024);
    chk("n256_wr_cnt", wr_cnt2, 1024);
    chk("n256_rq_left", rq2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
